// File: rtl/case_sel_offset_pipe.sv
// Registered select/offset decode: out = data + sel, illegal selects give 0 and are flagged; CSO_ERR_CNT_EN adds err_cnt.
// Latency 1 cycle, 1 beat/cycle; in_ready = !out_valid || out_ready, so a stalled output holds the beat.
module case_sel_offset_pipe #(
    parameter int DATA_W    = 4,
    parameter int SEL_W     = 2,
    parameter int NUM_CASES = 3,   // 1 <= NUM_CASES <= 2**SEL_W
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SEL_W-1:0]     in_sel,
    input  logic [DATA_W-1:0]    in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_illegal,
    input  logic                 clr_sticky,
    output logic                 illegal_seen
`ifdef CSO_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // One extra bit so NUM_CASES == 2**SEL_W is representable.
    localparam logic [SEL_W:0] NUM_CASES_L = (SEL_W + 1)'(NUM_CASES);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                illegal_q, illegal_d;
    logic                seen_q, seen_d;
    logic                accept;
    logic                sel_legal;
    logic [DATA_W-1:0]   dec_data;
    logic                dec_illegal;

    assign in_ready  = (state_q == ST_EMPTY) || out_ready;
    assign accept    = in_valid && in_ready;
    assign sel_legal = ({1'b0, in_sel} < NUM_CASES_L);

    // Default branch is kept even when every code is legal so illegal handling never disappears.
    always_comb begin
        dec_data    = '0;
        dec_illegal = 1'b0;
        case (sel_legal)
            1'b1: dec_data = in_data + DATA_W'(in_sel);
            default: begin
                dec_data    = '0;
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        illegal_d = illegal_q;
        seen_d    = seen_q;

        case (state_q)
            ST_EMPTY: begin
                if (accept) state_d = ST_FULL;
            end
            ST_FULL: begin
                if (accept)         state_d = ST_FULL;
                else if (out_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase

        if (accept) begin
            data_d    = dec_data;
            illegal_d = dec_illegal;
        end

        // Set beats clear when both happen in the same cycle.
        if (accept && dec_illegal) seen_d = 1'b1;
        else if (clr_sticky)       seen_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_EMPTY;
            data_q    <= '0;
            illegal_q <= 1'b0;
            seen_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            illegal_q <= illegal_d;
            seen_q    <= seen_d;
        end
    end

    assign out_valid    = (state_q == ST_FULL);
    assign out_data     = data_q;
    assign out_illegal  = illegal_q;
    assign illegal_seen = seen_q;

`ifdef CSO_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && dec_illegal) begin
            if (clr_sticky)              err_cnt_d = ERR_CNT_W'(1);
            else if (err_cnt_q != '1)    err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end else if (clr_sticky) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`else
    logic unused_err_cnt_w;
    assign unused_err_cnt_w = ^ERR_CNT_W;
`endif

endmodule

// File: tb/tb_case_sel_offset_pipe.sv
// Randomised + directed bench for case_sel_offset_pipe against a beat-level reference model.
module tb_case_sel_offset_pipe;
    localparam int DATA_W    = 4;
    localparam int SEL_W     = 2;
    localparam int NUM_CASES = 3;
    localparam int CNT_W     = 2;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst, in_valid, in_ready, out_valid, out_ready;
    logic [SEL_W-1:0]  in_sel;
    logic [DATA_W-1:0] in_data, out_data;
    logic              out_illegal, clr_sticky, illegal_seen;
`ifdef CSO_ERR_CNT_EN
    logic [CNT_W-1:0]  err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state: the beat held at the output and the sticky status.
    bit m_full = 0;
    int m_data = 0;
    bit m_ill  = 0;
    bit m_seen = 0;
    int m_cnt  = 0;

    always #5 clk = ~clk;

    case_sel_offset_pipe #(
        .DATA_W(DATA_W), .SEL_W(SEL_W), .NUM_CASES(NUM_CASES), .ERR_CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_illegal(out_illegal), .clr_sticky(clr_sticky), .illegal_seen(illegal_seen)
`ifdef CSO_ERR_CNT_EN
        , .err_cnt(err_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check in_ready, advance model at the edge, check outputs.
    task automatic step(input bit v, input int s, input int d, input bit ordy,
                        input bit clr, input bit r);
        bit exp_rdy, acc, ill;
        int res;
        in_valid = v; in_sel = SEL_W'(s); in_data = DATA_W'(d);
        out_ready = ordy; clr_sticky = clr; rst = r;
        #1;
        exp_rdy = !m_full || ordy;
        if (!r) chk("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        acc = v && exp_rdy;
        ill = (s >= NUM_CASES);
        res = ill ? 0 : (d + s) % (1 << DATA_W);
        @(posedge clk);
        if (r) begin
            m_full = 0; m_data = 0; m_ill = 0; m_seen = 0; m_cnt = 0;
        end else begin
            if (acc) begin
                m_full = 1; m_data = res; m_ill = ill;
            end else if (ordy) begin
                m_full = 0;
            end
            if (acc && ill) begin
                m_seen = 1;
                m_cnt  = clr ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
            end else if (clr) begin
                m_seen = 0;
                m_cnt  = 0;
            end
        end
        @(negedge clk);
        chk("out_valid",    {31'b0, out_valid},    {31'b0, m_full});
        chk("out_data",     {28'b0, out_data},     m_data);
        chk("out_illegal",  {31'b0, out_illegal},  {31'b0, m_ill});
        chk("illegal_seen", {31'b0, illegal_seen}, {31'b0, m_seen});
`ifdef CSO_ERR_CNT_EN
        chk("err_cnt",      {30'b0, err_cnt},      m_cnt);
`endif
    endtask

    initial begin
        in_valid = 0; in_sel = '0; in_data = '0; out_ready = 1; clr_sticky = 0; rst = 1;

        step(0, 0, 0, 1, 0, 1);
        step(0, 0, 0, 1, 0, 1);
        chk("rst_in_ready", {31'b0, in_ready}, 1);

        // Back-to-back legal selects.
        step(1, 0, 5, 1, 0, 0); chk("seq0", {28'b0, out_data}, 5);
        step(1, 1, 5, 1, 0, 0); chk("seq1", {28'b0, out_data}, 6);
        step(1, 2, 5, 1, 0, 0); chk("seq2", {28'b0, out_data}, 7);

        // Illegal select.
        step(1, 3, 'hA, 1, 0, 0);
        chk("illegal_data", {28'b0, out_data}, 0);
        chk("illegal_flag", {31'b0, out_illegal}, 1);

        // Wrap.
        step(1, 1, 'hF, 1, 0, 0);
        chk("wrap_data", {28'b0, out_data}, 0);

        // Stall for three cycles, then release.
        step(1, 2, 3, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 9, 0, 0, 0);
            chk("stall_data", {28'b0, out_data}, 5);
        end
        step(1, 0, 9, 1, 0, 0);
        chk("release_data", {28'b0, out_data}, 9);

        // Clear coinciding with an illegal accept, then saturation.
        step(1, 3, 1, 1, 1, 0);
        chk("clr_set_seen", {31'b0, illegal_seen}, 1);
        for (int i = 0; i < 5; i++) step(1, 3, i, 1, 0, 0);
        step(0, 0, 0, 1, 1, 0);
        chk("clr_seen", {31'b0, illegal_seen}, 0);

        // Reset while full and stalled.
        step(1, 3, 3, 1, 0, 0);
        step(1, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_stall_valid", {31'b0, out_valid}, 0);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom_range(0, 3), $urandom_range(0, 15),
                 ($urandom_range(0, 9) < 7), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
